// File: rtl/vga_timing_pkg.sv
// Raster timing constants (640x480@60 defaults) and helpers that turn
// porch/sync widths into totals and sync-window bounds. Shared with the
// renderer so both agree on the visible grid.
package vga_timing_pkg;

  // Beam positions are carried as 10-bit values, so totals cannot exceed 1024.
  localparam int POS_W     = 10;
  localparam int POS_LIMIT = 1 << POS_W;

  typedef logic [POS_W-1:0] pos_t;

  // 640x480@60 on a 25.175 MHz pixel clock.
  localparam int H_DISPLAY_DEF = 640;
  localparam int H_FRONT_DEF   = 16;
  localparam int H_SYNC_DEF    = 96;
  localparam int H_BACK_DEF    = 48;
  localparam int V_DISPLAY_DEF = 480;
  localparam int V_BOTTOM_DEF  = 10;
  localparam int V_SYNC_DEF    = 2;
  localparam int V_TOP_DEF     = 33;
  localparam int FRAME_DIV_DEF = 2;

  // Total positions along one axis (visible + porches + sync).
  function automatic int axis_total(input int disp, input int porch_a,
                                    input int sync, input int porch_b);
    return disp + porch_a + sync + porch_b;
  endfunction

  // First position of the sync pulse (right after the front porch).
  function automatic int sync_first(input int disp, input int front);
    return disp + front;
  endfunction

  // Last position of the sync pulse, inclusive.
  function automatic int sync_last(input int disp, input int front, input int sync);
    return disp + front + sync - 1;
  endfunction

  localparam int H_TOTAL_DEF = axis_total(H_DISPLAY_DEF, H_FRONT_DEF, H_SYNC_DEF, H_BACK_DEF);
  localparam int V_TOTAL_DEF = axis_total(V_DISPLAY_DEF, V_BOTTOM_DEF, V_SYNC_DEF, V_TOP_DEF);

endpackage

// File: rtl/wrap_counter.sv
// Enabled modulo counter 0..MAX with a reset preset. Exposes the next-state
// value so the caller can register decodes in step with the count, and a
// wrap pulse that is high when an enabled edge takes the count from MAX to 0.
module wrap_counter #(
  parameter int MAX = 1,
  parameter int W   = 1
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         en,
  input  logic [W-1:0] load,
  output logic [W-1:0] count,
  output logic [W-1:0] count_next,
  output logic         wrap
);

  localparam logic [W-1:0] MAX_V = W'(MAX);

  logic [W-1:0] count_q;
  logic [W-1:0] count_d;
  logic         at_max;

  assign at_max = (count_q == MAX_V);

  // Next count: hold when disabled, otherwise step and fold MAX back to zero.
  always_comb begin
    count_d = count_q;
    if (en) begin
      count_d = at_max ? '0 : count_q + W'(1);
    end
  end

  // Count register; reset loads the caller's preset value.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      count_q <= load;
    end else begin
      count_q <= count_d;
    end
  end

  assign count      = count_q;
  assign count_next = count_d;
  assign wrap       = en & at_max;

endmodule

// File: rtl/vga_timing_gen.sv
// VGA raster timing generator: beam position, syncs, visible flag and
// single-cycle line/frame/motion strobes, all registered on clk. The reset
// state is the decode of the last raster position, so the first enabled edge
// after reset simply wraps into (0,0) like any other frame.
module vga_timing_gen
  import vga_timing_pkg::*;
#(
  parameter int H_DISPLAY = H_DISPLAY_DEF,
  parameter int H_FRONT   = H_FRONT_DEF,
  parameter int H_SYNC    = H_SYNC_DEF,
  parameter int H_BACK    = H_BACK_DEF,
  parameter int V_DISPLAY = V_DISPLAY_DEF,
  parameter int V_BOTTOM  = V_BOTTOM_DEF,
  parameter int V_SYNC    = V_SYNC_DEF,
  parameter int V_TOP     = V_TOP_DEF,
  parameter bit SYNC_POL  = 1'b0,
  parameter int FRAME_DIV = FRAME_DIV_DEF
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       pix_en,
  output logic       hsync,
  output logic       vsync,
  output logic       display_on,
  output logic [9:0] hpos,
  output logic [9:0] vpos,
  output logic       line_start,
  output logic       frame_start,
  output logic       move_tick,
  output logic [7:0] frame_count
);

  localparam int H_TOTAL = axis_total(H_DISPLAY, H_FRONT, H_SYNC, H_BACK);
  localparam int V_TOTAL = axis_total(V_DISPLAY, V_BOTTOM, V_SYNC, V_TOP);
  localparam int DIV_W   = (FRAME_DIV > 1) ? $clog2(FRAME_DIV) : 1;

  localparam pos_t H_LOAD   = pos_t'(H_TOTAL - 1);
  localparam pos_t V_LOAD   = pos_t'(V_TOTAL - 1);
  localparam pos_t H_DISP_V = pos_t'(H_DISPLAY);
  localparam pos_t V_DISP_V = pos_t'(V_DISPLAY);
  localparam pos_t HS_FIRST = pos_t'(sync_first(H_DISPLAY, H_FRONT));
  localparam pos_t HS_LAST  = pos_t'(sync_last(H_DISPLAY, H_FRONT, H_SYNC));
  localparam pos_t VS_FIRST = pos_t'(sync_first(V_DISPLAY, V_BOTTOM));
  localparam pos_t VS_LAST  = pos_t'(sync_last(V_DISPLAY, V_BOTTOM, V_SYNC));

  // Reject rasters that do not fit the 10-bit position outputs.
  if (H_TOTAL > POS_LIMIT) begin : g_h_total_too_big
    $error("vga_timing_gen: H_TOTAL exceeds 1024");
  end
  if (V_TOTAL > POS_LIMIT) begin : g_v_total_too_big
    $error("vga_timing_gen: V_TOTAL exceeds 1024");
  end
  if (FRAME_DIV < 1) begin : g_frame_div_too_small
    $error("vga_timing_gen: FRAME_DIV must be at least 1");
  end

  // Position counters and frame divider.
  pos_t             h_count;
  pos_t             h_next;
  logic             h_wrap;
  pos_t             v_count;
  pos_t             v_next;
  logic             v_wrap;
  logic [DIV_W-1:0] div_count;
  logic [DIV_W-1:0] div_next;
  logic             div_wrap;

  // Raster events, each already qualified by pix_en through h_wrap.
  logic frame_entry;
  logic vblank_entry;

  // Registered outputs and their next-state values.
  logic       hsync_q, hsync_d;
  logic       vsync_q, vsync_d;
  logic       display_on_q, display_on_d;
  logic       line_start_q, line_start_d;
  logic       frame_start_q, frame_start_d;
  logic       move_tick_q, move_tick_d;
  logic [7:0] frame_count_q, frame_count_d;

  wrap_counter #(
    .MAX (H_TOTAL - 1),
    .W   (POS_W)
  ) u_hcount (
    .clk        (clk),
    .rst_n      (rst_n),
    .en         (pix_en),
    .load       (H_LOAD),
    .count      (h_count),
    .count_next (h_next),
    .wrap       (h_wrap)
  );

  // The line counter only moves when the column counter wraps.
  wrap_counter #(
    .MAX (V_TOTAL - 1),
    .W   (POS_W)
  ) u_vcount (
    .clk        (clk),
    .rst_n      (rst_n),
    .en         (h_wrap),
    .load       (V_LOAD),
    .count      (v_count),
    .count_next (v_next),
    .wrap       (v_wrap)
  );

  assign frame_entry  = h_wrap & v_wrap;
  assign vblank_entry = h_wrap & (v_next == V_DISP_V);

  // Frame divider steps once per frame at the top of vertical blanking.
  wrap_counter #(
    .MAX (FRAME_DIV - 1),
    .W   (DIV_W)
  ) u_frame_div (
    .clk        (clk),
    .rst_n      (rst_n),
    .en         (vblank_entry),
    .load       ({DIV_W{1'b0}}),
    .count      (div_count),
    .count_next (div_next),
    .wrap       (div_wrap)
  );

  // Only the wrap pulse of the divider matters outside it.
  logic unused_div;
  assign unused_div = ^{div_count, div_next};

  // Decode syncs/visibility from the next position so they line up with hpos/vpos.
  always_comb begin
    hsync_d       = ((h_next >= HS_FIRST) && (h_next <= HS_LAST)) ? SYNC_POL : ~SYNC_POL;
    vsync_d       = ((v_next >= VS_FIRST) && (v_next <= VS_LAST)) ? SYNC_POL : ~SYNC_POL;
    display_on_d  = (h_next < H_DISP_V) && (v_next < V_DISP_V);
    line_start_d  = h_wrap;
    frame_start_d = frame_entry;
    move_tick_d   = div_wrap;
    frame_count_d = frame_entry ? frame_count_q + 8'd1 : frame_count_q;
  end

  // Output registers; reset values equal the decode of the last raster position.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      hsync_q       <= ~SYNC_POL;
      vsync_q       <= ~SYNC_POL;
      display_on_q  <= 1'b0;
      line_start_q  <= 1'b0;
      frame_start_q <= 1'b0;
      move_tick_q   <= 1'b0;
      frame_count_q <= 8'hFF;
    end else begin
      hsync_q       <= hsync_d;
      vsync_q       <= vsync_d;
      display_on_q  <= display_on_d;
      line_start_q  <= line_start_d;
      frame_start_q <= frame_start_d;
      move_tick_q   <= move_tick_d;
      frame_count_q <= frame_count_d;
    end
  end

  assign hsync       = hsync_q;
  assign vsync       = vsync_q;
  assign display_on  = display_on_q;
  assign hpos        = h_count;
  assign vpos        = v_count;
  assign line_start  = line_start_q;
  assign frame_start = frame_start_q;
  assign move_tick   = move_tick_q;
  assign frame_count = frame_count_q;

endmodule

// File: tb/tb_vga_timing_gen.sv
// Bench for vga_timing_gen on a shrunken raster (16x12 total, 8x6 visible)
// so whole frames fit in a short run. Two instances share the stimulus:
// dut uses FRAME_DIV=2, dut1 uses FRAME_DIV=1. Stimulus pushes the expected
// outputs of both into a queue; a monitor pops and compares every cycle and
// records strobe/sync events for the directed period checks.
module tb_vga_timing_gen;

  // Small raster: H 8+2+3+3=16, V 6+2+2+2=12, frame = 192 enabled edges.
  localparam int HT    = 16;
  localparam int VT    = 12;
  localparam int HD    = 8;
  localparam int VD    = 6;
  localparam int HS_LO = 10;
  localparam int HS_HI = 12;
  localparam int VS_LO = 8;
  localparam int VS_HI = 9;
  localparam int FD    = 2;

  typedef struct packed {
    logic       hs;
    logic       vs;
    logic       disp;
    logic [9:0] h;
    logic [9:0] v;
    logic       ls;
    logic       fs;
    logic       mt;
    logic [7:0] fc;
  } obs_t;

  typedef struct packed {
    obs_t a;
    obs_t b;
  } exp_t;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       pix_en;
  logic       hsync, vsync, display_on, line_start, frame_start, move_tick;
  logic [9:0] hpos, vpos;
  logic [7:0] frame_count;
  logic       hsync1, vsync1, display_on1, line_start1, frame_start1, move_tick1;
  logic [9:0] hpos1, vpos1;
  logic [7:0] frame_count1;

  int checks = 0;
  int errors = 0;

  exp_t exp_q[$];

  // Reference model state.
  int         m_h, m_v, m_div;
  logic [7:0] m_fc;
  logic       m_ls, m_fs, m_mt, m_mt1;

  // Event records (cycle numbers relative to the last clear_events).
  int   cyc = 0;
  int   ev_base = 0;
  int   fs_t[$];
  int   fs_fc[$];
  int   ls_t[$];
  int   mt_t[$];
  int   mt_fc[$];
  int   mt_h[$];
  int   mt_v[$];
  int   mt1_t[$];
  int   hs_low, vs_low, hs_first_h, vs_first_v, disp_fall_h;
  logic prev_disp;

  always #5 clk = ~clk;

  vga_timing_gen #(
    .H_DISPLAY(8), .H_FRONT(2), .H_SYNC(3), .H_BACK(3),
    .V_DISPLAY(6), .V_BOTTOM(2), .V_SYNC(2), .V_TOP(2),
    .SYNC_POL(1'b0), .FRAME_DIV(2)
  ) dut (
    .clk(clk), .rst_n(rst_n), .pix_en(pix_en),
    .hsync(hsync), .vsync(vsync), .display_on(display_on),
    .hpos(hpos), .vpos(vpos),
    .line_start(line_start), .frame_start(frame_start), .move_tick(move_tick),
    .frame_count(frame_count)
  );

  vga_timing_gen #(
    .H_DISPLAY(8), .H_FRONT(2), .H_SYNC(3), .H_BACK(3),
    .V_DISPLAY(6), .V_BOTTOM(2), .V_SYNC(2), .V_TOP(2),
    .SYNC_POL(1'b0), .FRAME_DIV(1)
  ) dut1 (
    .clk(clk), .rst_n(rst_n), .pix_en(pix_en),
    .hsync(hsync1), .vsync(vsync1), .display_on(display_on1),
    .hpos(hpos1), .vpos(vpos1),
    .line_start(line_start1), .frame_start(frame_start1), .move_tick(move_tick1),
    .frame_count(frame_count1)
  );

  function automatic obs_t model_obs(input int h, input int v, input logic ls,
                                     input logic fs, input logic mt, input logic [7:0] fc);
    obs_t o;
    o.hs   = (h >= HS_LO && h <= HS_HI) ? 1'b0 : 1'b1;
    o.vs   = (v >= VS_LO && v <= VS_HI) ? 1'b0 : 1'b1;
    o.disp = (h < HD) && (v < VD);
    o.h    = 10'(h);
    o.v    = 10'(v);
    o.ls   = ls;
    o.fs   = fs;
    o.mt   = mt;
    o.fc   = fc;
    return o;
  endfunction

  function automatic int qat(input int q[$], input int i);
    return (i < q.size()) ? q[i] : -1;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s actual=%0d required=%0d", name, $signed(act), $signed(req));
    end else begin
      $display("ok   %s = %0d", name, $signed(act));
    end
  endtask

  // One clock of stimulus: drive inputs, advance the model, queue expectations.
  task automatic step(input logic r, input logic en);
    exp_t e;
    @(negedge clk);
    rst_n  = r;
    pix_en = en;
    m_ls   = 1'b0;
    m_fs   = 1'b0;
    m_mt   = 1'b0;
    m_mt1  = 1'b0;
    if (!r) begin
      m_h   = HT - 1;
      m_v   = VT - 1;
      m_fc  = 8'hFF;
      m_div = 0;
    end else if (en) begin
      if (m_h == HT - 1) begin
        m_h = 0;
        m_v = (m_v == VT - 1) ? 0 : m_v + 1;
      end else begin
        m_h = m_h + 1;
      end
      m_ls = (m_h == 0);
      if (m_h == 0 && m_v == 0) begin
        m_fs = 1'b1;
        m_fc = m_fc + 8'd1;
      end
      if (m_h == 0 && m_v == VD) begin
        m_mt1 = 1'b1;
        if (m_div == FD - 1) begin
          m_mt  = 1'b1;
          m_div = 0;
        end else begin
          m_div = m_div + 1;
        end
      end
    end
    e.a = model_obs(m_h, m_v, m_ls, m_fs, m_mt, m_fc);
    e.b = model_obs(m_h, m_v, m_ls, m_fs, m_mt1, m_fc);
    exp_q.push_back(e);
  endtask

  task automatic settle();
    @(posedge clk);
    #2;
  endtask

  task automatic clear_events();
    fs_t.delete();
    fs_fc.delete();
    ls_t.delete();
    mt_t.delete();
    mt_fc.delete();
    mt_h.delete();
    mt_v.delete();
    mt1_t.delete();
    hs_low      = 0;
    vs_low      = 0;
    hs_first_h  = -1;
    vs_first_v  = -1;
    disp_fall_h = -1;
    prev_disp   = display_on;
    ev_base     = cyc;
  endtask

  // Monitor: compare every presented cycle against the queued expectation.
  always begin
    exp_t act;
    exp_t e;
    int   rel;
    @(posedge clk);
    #1;
    cyc++;
    rel   = cyc - ev_base;
    act.a = {hsync, vsync, display_on, hpos, vpos, line_start, frame_start, move_tick, frame_count};
    act.b = {hsync1, vsync1, display_on1, hpos1, vpos1, line_start1, frame_start1, move_tick1, frame_count1};
    if (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      checks++;
      if (act !== e) begin
        errors++;
        $display("FAIL cycle_%0d h=%0d v=%0d dut actual=%h required=%h dut1 actual=%h required=%h",
                 cyc, e.a.h, e.a.v, act.a, e.a, act.b, e.b);
      end
    end
    if (frame_start === 1'b1) begin
      fs_t.push_back(rel);
      fs_fc.push_back(int'(frame_count));
    end
    if (line_start === 1'b1) ls_t.push_back(rel);
    if (move_tick === 1'b1) begin
      mt_t.push_back(rel);
      mt_fc.push_back(int'(frame_count));
      mt_h.push_back(int'(hpos));
      mt_v.push_back(int'(vpos));
    end
    if (move_tick1 === 1'b1) mt1_t.push_back(rel);
    if (hsync === 1'b0) begin
      if (hs_first_h < 0) hs_first_h = int'(hpos);
      hs_low++;
    end
    if (vsync === 1'b0) begin
      if (vs_first_v < 0) vs_first_v = int'(vpos);
      vs_low++;
    end
    if (prev_disp === 1'b1 && display_on === 1'b0 && disp_fall_h < 0) disp_fall_h = int'(hpos);
    prev_disp = display_on;
  end

  initial begin
    #500000;
    $display("FAIL watchdog time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    rst_n  = 1'b0;
    pix_en = 1'b0;
    m_h = HT - 1; m_v = VT - 1; m_div = 0; m_fc = 8'hFF;
    m_ls = 1'b0; m_fs = 1'b0; m_mt = 1'b0; m_mt1 = 1'b0;

    // Reset for 3 cycles with pix_en high: reset must win.
    for (int i = 0; i < 3; i++) step(1'b0, 1'b1);
    settle();
    chk("reset_hpos", hpos, 15);
    chk("reset_vpos", vpos, 11);
    chk("reset_hsync", hsync, 1);
    chk("reset_vsync", vsync, 1);
    chk("reset_display_on", display_on, 0);
    chk("reset_strobes", {line_start, frame_start, move_tick}, 0);
    chk("reset_frame_count", frame_count, 255);

    // Four free-running frames.
    clear_events();
    step(1'b1, 1'b1);
    settle();
    chk("first_hpos", hpos, 0);
    chk("first_vpos", vpos, 0);
    chk("first_display_on", display_on, 1);
    chk("first_line_start", line_start, 1);
    chk("first_frame_start", frame_start, 1);
    chk("first_frame_count", frame_count, 0);
    for (int i = 1; i < 4 * HT * VT; i++) step(1'b1, 1'b1);
    settle();
    chk("display_fall_hpos", disp_fall_h, 8);
    chk("hsync_first_low_hpos", hs_first_h, 10);
    chk("hsync_low_cycles_4frames", hs_low, 144);
    chk("vsync_first_low_vpos", vs_first_v, 8);
    chk("vsync_low_cycles_4frames", vs_low, 128);
    chk("line_start_count", ls_t.size(), 48);
    chk("line_start_period", qat(ls_t, 1) - qat(ls_t, 0), 16);
    chk("frame_start_count", fs_t.size(), 4);
    chk("frame_start_period", qat(fs_t, 1) - qat(fs_t, 0), 192);
    chk("frame_count_second_frame", qat(fs_fc, 1), 1);
    chk("move_tick_count", mt_t.size(), 2);
    chk("move_tick_first_cycle", qat(mt_t, 0), 289);
    chk("move_tick_first_hpos", qat(mt_h, 0), 0);
    chk("move_tick_first_vpos", qat(mt_v, 0), 6);
    chk("move_tick_first_frame_count", qat(mt_fc, 0), 1);
    chk("move_tick_period", qat(mt_t, 1) - qat(mt_t, 0), 384);
    chk("div1_move_tick_count", mt1_t.size(), 4);
    chk("div1_move_tick_period", qat(mt1_t, 1) - qat(mt1_t, 0), 192);

    // pix_en alternating: everything runs at half rate, strobes stay 1 cycle.
    clear_events();
    for (int i = 0; i < 4 * HT * VT; i++) step(1'b1, (i % 2) == 0);
    settle();
    chk("alt_frame_start_count", fs_t.size(), 2);
    chk("alt_frame_period", qat(fs_t, 1) - qat(fs_t, 0), 384);
    chk("alt_line_start_count", ls_t.size(), 24);
    chk("alt_line_period", qat(ls_t, 1) - qat(ls_t, 0), 32);
    chk("alt_move_tick_cycle", qat(mt_t, 0), 577);
    chk("alt_move_tick_frame_count", qat(mt_fc, 0), 5);
    chk("alt_div1_move_tick_period", qat(mt1_t, 1) - qat(mt1_t, 0), 384);
    chk("alt_end_frame_count", frame_count, 5);

    // Mid-frame reset at (5,3) with pix_en low.
    for (int i = 0; i < 400 && !(m_h == 5 && m_v == 3); i++) step(1'b1, 1'b1);
    settle();
    chk("mid_hpos_before_reset", hpos, 5);
    chk("mid_vpos_before_reset", vpos, 3);
    step(1'b0, 1'b0);
    settle();
    chk("mid_reset_hpos", hpos, 15);
    chk("mid_reset_vpos", vpos, 11);
    chk("mid_reset_frame_count", frame_count, 255);
    chk("mid_reset_display_on", display_on, 0);
    clear_events();
    for (int i = 0; i < 2 * HT * VT + 4; i++) step(1'b1, 1'b1);
    settle();
    chk("restart_first_frame_count", qat(fs_fc, 0), 0);
    chk("restart_move_tick_count", mt_t.size(), 1);
    chk("restart_move_tick_cycle", qat(mt_t, 0), 289);
    chk("restart_move_tick_frame_count", qat(mt_fc, 0), 1);
    chk("restart_div1_move_tick_count", mt1_t.size(), 2);
    chk("scoreboard_drained", exp_q.size(), 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
